// File: rtl/mips_sys_pkg.sv
// ============================================================================
//  Package : mips_sys_pkg
//  Service-code constants and responder state/kind enums for the MIPS
//  syscall console responder.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_sys_pkg;

    localparam logic [31:0] SVC_PRINT_STR  = 32'd4;
    localparam logic [31:0] SVC_EXIT       = 32'd10;
    localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;
    localparam logic [31:0] SVC_PRINT_HEX  = 32'd34;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STR_RD   = 3'd1,
        STR_WAIT = 3'd2,
        EMIT     = 3'd3,
        DONE     = 3'd4,
        HALT     = 3'd5
    } resp_state_t;

    typedef enum logic [1:0] {
        SK_CHAR = 2'd0,
        SK_HEX  = 2'd1,
        SK_STR  = 2'd2
    } svc_kind_t;

endpackage

`default_nettype wire

// File: rtl/hex_nibble_ascii.sv
// ============================================================================
//  Module  : hex_nibble_ascii
//  Maps a 4-bit nibble to its lowercase ASCII hex digit.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_nibble_ascii (
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        if (nibble_i < 4'd10) ascii_o = 8'h30 + {4'h0, nibble_i};
        else                  ascii_o = 8'h57 + {4'h0, nibble_i};
    end

endmodule

`default_nettype wire

// File: rtl/syscall_responder.sv
// ============================================================================
//  Module  : syscall_responder
//  Executes MIPS console syscalls (print_char/hex/string, exit) from a
//  single-request handshake, reading strings over a byte memory port.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module syscall_responder
    import mips_sys_pkg::*;
#(
    parameter int MAX_STR_LEN = 256,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       svc_code,
    input  logic [31:0]       svc_arg,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              done,
    output logic              halted,
    output logic              err
);

    localparam int CNT_W = $clog2(MAX_STR_LEN + 1);

    resp_state_t       state_q;
    svc_kind_t         kind_q;
    logic [31:0]       arg_q;
    logic [ADDR_W-1:0] offset_q;
    logic [CNT_W-1:0]  emitted_q;
    logic [3:0]        nib_cnt_q;
    logic              req_ready_q, mem_rd_en_q, out_valid_q, done_q, halted_q, err_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        out_byte_q;

    logic [ADDR_W-1:0] offset_d;
    logic [CNT_W-1:0]  emitted_d;
    logic [7:0]        w_hex_ascii;

    assign offset_d  = offset_q + ADDR_W'(1);
    assign emitted_d = emitted_q + CNT_W'(1);

    // arg_q is shifted left one nibble per hex digit, so the top nibble is always next
    hex_nibble_ascii u_hex (
        .nibble_i (arg_q[31:28]),
        .ascii_o  (w_hex_ascii)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            kind_q      <= SK_CHAR;
            arg_q       <= '0;
            offset_q    <= '0;
            emitted_q   <= '0;
            nib_cnt_q   <= '0;
            req_ready_q <= 1'b1;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            done_q      <= 1'b0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_rd_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        arg_q       <= svc_arg;
                        offset_q    <= '0;
                        emitted_q   <= '0;
                        nib_cnt_q   <= '0;
                        req_ready_q <= 1'b0;
                        case (svc_code)
                            SVC_PRINT_CHAR: begin
                                kind_q      <= SK_CHAR;
                                out_byte_q  <= svc_arg[7:0];
                                out_valid_q <= 1'b1;
                                state_q     <= EMIT;
                            end
                            SVC_PRINT_HEX: begin
                                kind_q      <= SK_HEX;
                                out_byte_q  <= 8'h30;
                                out_valid_q <= 1'b1;
                                state_q     <= EMIT;
                            end
                            SVC_PRINT_STR: begin
                                kind_q      <= SK_STR;
                                mem_rd_en_q <= 1'b1;
                                mem_addr_q  <= ADDR_W'(svc_arg);
                                state_q     <= STR_RD;
                            end
                            SVC_EXIT: begin
                                done_q   <= 1'b1;
                                halted_q <= 1'b1;
                                state_q  <= HALT;
                            end
                            default: begin
                                done_q  <= 1'b1;
                                err_q   <= 1'b1;
                                state_q <= DONE;
                            end
                        endcase
                    end
                end
                STR_RD: state_q <= STR_WAIT;
                STR_WAIT: begin
                    if (mem_rd_data == 8'h00) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        out_byte_q  <= mem_rd_data;
                        out_valid_q <= 1'b1;
                        state_q     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        case (kind_q)
                            SK_HEX: begin
                                if (nib_cnt_q == 4'd9) begin
                                    done_q  <= 1'b1;
                                    state_q <= DONE;
                                end else begin
                                    nib_cnt_q   <= nib_cnt_q + 4'd1;
                                    out_valid_q <= 1'b1;
                                    if (nib_cnt_q == 4'd0) begin
                                        out_byte_q <= 8'h78;
                                    end else begin
                                        out_byte_q <= w_hex_ascii;
                                        arg_q      <= arg_q << 4;
                                    end
                                end
                            end
                            SK_STR: begin
                                emitted_q <= emitted_d;
                                if (emitted_d == CNT_W'(MAX_STR_LEN)) begin
                                    done_q  <= 1'b1;
                                    err_q   <= 1'b1;
                                    state_q <= DONE;
                                end else begin
                                    offset_q    <= offset_d;
                                    mem_rd_en_q <= 1'b1;
                                    mem_addr_q  <= ADDR_W'(arg_q) + offset_d;
                                    state_q     <= STR_RD;
                                end
                            end
                            default: begin
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end
                        endcase
                    end
                end
                DONE: begin
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                HALT:    state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;
    assign done      = done_q;
    assign halted    = halted_q;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_syscall_responder.sv
// ============================================================================
//  Module  : tb_syscall_responder
//  Self-checking bench for syscall_responder (MAX_STR_LEN=4).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_syscall_responder;

    localparam int MAXL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] svc_code = '0;
    logic [31:0] svc_arg = '0;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_byte;
    logic        done, halted, err;

    syscall_responder #(.MAX_STR_LEN(MAXL), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .svc_code(svc_code), .svc_arg(svc_arg), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_byte(out_byte), .done(done),
        .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          rdy_mode = 0;
    logic [7:0]  outq[$];
    logic [31:0] addrq[$];
    logic [7:0]  mem[1024];
    bit          stall_prev = 0;
    logic [7:0]  stall_byte = '0;

    // Byte memory: data valid the cycle after the strobe, garbage otherwise
    initial forever begin
        @(posedge clk);
        if (mem_rd_en) mem_rd_data <= mem[mem_addr[9:0]];
        else           mem_rd_data <= 8'($urandom);
    end

    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_byte !== stall_byte) begin
                    n_fail++;
                    $display("FAIL hold_stable: got valid=%b byte=%h, required valid=1 byte=%h",
                             out_valid, out_byte, stall_byte);
                end
            end
            if (out_valid && out_ready) outq.push_back(out_byte);
            if (mem_rd_en) addrq.push_back(mem_addr);
            if (done) done_cnt++;
            if (err) err_cnt++;
            stall_prev = out_valid && !out_ready;
            stall_byte = out_byte;
        end
    end

    function automatic string bq2s();
        string s = "";
        foreach (outq[i]) s = {s, $sformatf("%02h ", outq[i])};
        return s;
    endfunction

    function automatic string aq2s();
        string s = "";
        foreach (addrq[i]) s = {s, $sformatf("%08h ", addrq[i])};
        return s;
    endfunction

    // Reference model: expected console bytes, read addresses and err flag
    function automatic void model(input logic [31:0] code, input logic [31:0] arg,
                                  output string eb, output string ea, output int ee);
        string hs;
        logic [31:0] a;
        eb = ""; ea = ""; ee = 0;
        if (code == 32'd11) begin
            eb = $sformatf("%02h ", arg[7:0]);
        end else if (code == 32'd34) begin
            hs = $sformatf("0x%08h", arg);
            for (int i = 0; i < hs.len(); i++) eb = {eb, $sformatf("%02h ", hs[i])};
        end else if (code == 32'd4) begin
            for (int i = 0; ; i++) begin
                if (i == MAXL) begin ee = 1; break; end
                a = arg + 32'(i);
                ea = {ea, $sformatf("%08h ", a)};
                if (mem[a[9:0]] == 8'h00) break;
                eb = {eb, $sformatf("%02h ", mem[a[9:0]])};
            end
        end else begin
            ee = 1;
        end
    endfunction

    task automatic clear_obs();
        outq.delete(); addrq.delete(); done_cnt = 0; err_cnt = 0;
    endtask

    task automatic send(input logic [31:0] code, input logic [31:0] arg, output bit ok);
        ok = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 300; i++) begin
            if (req_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin
            req_valid = 1'b1; svc_code = code; svc_arg = arg;
            @(posedge clk); #1;
            req_valid = 1'b0; svc_code = $urandom; svc_arg = $urandom;
        end
    endtask

    task automatic wait_done(output int lat, output logic err_at_done);
        lat = -1; err_at_done = 1'bx;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (done) begin lat = i; err_at_done = err; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic run_svc(input logic [31:0] code, input logic [31:0] arg,
                           output int lat, output logic err_at_done);
        bit ok;
        clear_obs();
        send(code, arg, ok);
        if (!ok) begin lat = -2; err_at_done = 1'bx; end
        else wait_done(lat, err_at_done);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({req_ready, mem_rd_en, mem_addr, out_valid, out_byte, done, err, halted} !==
            {1'b1, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b rd=%b addr=%h ov=%b ob=%h d=%b e=%b h=%b, required 1 0 0 0 0 0 0 0",
                     req_ready, mem_rd_en, mem_addr, out_valid, out_byte, done, err, halted);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_reset: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_print_char();
        bit ok;
        rdy_mode = 0; clear_obs();
        send(32'd11, 32'h41, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL char_accept: got %b, required 1", ok); end
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_byte, done} !== {1'b1, 8'h41, 1'b0}) begin
            n_fail++; $display("FAIL char_n1: got ov=%b ob=%h done=%b, required 1 41 0", out_valid, out_byte, done);
        end
        @(negedge clk);
        n_checks++;
        if ({done, err, out_valid} !== 3'b100) begin
            n_fail++; $display("FAIL char_n2: got done=%b err=%b ov=%b, required 1 0 0", done, err, out_valid);
        end
        @(negedge clk);
        n_checks++;
        if ({req_ready, done} !== 2'b10) begin
            n_fail++; $display("FAIL char_n3: got rdy=%b done=%b, required 1 0", req_ready, done);
        end
        n_checks++;
        if (bq2s() != "41 ") begin n_fail++; $display("FAIL char_bytes: got '%s', required '41 '", bq2s()); end
    endtask

    task automatic test_print_hex();
        int lat; logic e;
        rdy_mode = 1;
        run_svc(32'd34, 32'hDEADBEEF, lat, e);
        n_checks++;
        if (bq2s() != "30 78 64 65 61 64 62 65 65 66 " || lat < 10 || e !== 1'b0 || done_cnt != 1) begin
            n_fail++; $display("FAIL hex_bytes: got '%s' lat=%0d err=%b dones=%0d, required '30 78 64 65 61 64 62 65 65 66 ' err=0 dones=1",
                               bq2s(), lat, e, done_cnt);
        end
    endtask

    task automatic test_print_string();
        int lat; logic e;
        rdy_mode = 2;
        mem[10'h100] = 8'h48; mem[10'h101] = 8'h69; mem[10'h102] = 8'h00;
        run_svc(32'd4, 32'h100, lat, e);
        n_checks++;
        if (bq2s() != "48 69 " || aq2s() != "00000100 00000101 00000102 ") begin
            n_fail++; $display("FAIL str_hi: got bytes '%s' addrs '%s', required '48 69 ' / '00000100 00000101 00000102 '", bq2s(), aq2s());
        end
        n_checks++;
        if (e !== 1'b0 || done_cnt != 1 || lat < 0) begin
            n_fail++; $display("FAIL str_hi_done: got err=%b dones=%0d lat=%0d, required err=0 dones=1", e, done_cnt, lat);
        end
        // Address offset wraps past the top of the address space
        mem[10'h3FF] = 8'h41; mem[10'h000] = 8'h42; mem[10'h001] = 8'h00;
        run_svc(32'd4, 32'hFFFFFFFF, lat, e);
        n_checks++;
        if (bq2s() != "41 42 " || aq2s() != "ffffffff 00000000 00000001 " || e !== 1'b0) begin
            n_fail++; $display("FAIL str_wrap: got bytes '%s' addrs '%s' err=%b, required '41 42 ' / 'ffffffff 00000000 00000001 ' err=0", bq2s(), aq2s(), e);
        end
    endtask

    task automatic test_empty_and_overrun();
        int lat; logic e;
        rdy_mode = 0;
        mem[10'h300] = 8'h00;
        run_svc(32'd4, 32'h300, lat, e);
        n_checks++;
        if (outq.size() != 0 || aq2s() != "00000300 " || e !== 1'b0 || done_cnt != 1 || err_cnt != 0) begin
            n_fail++; $display("FAIL str_empty: got bytes '%s' addrs '%s' err=%b dones=%0d, required none / '00000300 ' err=0 dones=1",
                               bq2s(), aq2s(), e, done_cnt);
        end
        for (int i = 0; i < 8; i++) mem[10'h200 + 10'(i)] = 8'h41 + 8'(i);
        rdy_mode = 2;
        run_svc(32'd4, 32'h200, lat, e);
        n_checks++;
        if (bq2s() != "41 42 43 44 " || aq2s() != "00000200 00000201 00000202 00000203 ") begin
            n_fail++; $display("FAIL str_overrun: got bytes '%s' addrs '%s', required '41 42 43 44 ' / 00000200..00000203", bq2s(), aq2s());
        end
        n_checks++;
        if (e !== 1'b1 || err_cnt != 1 || done_cnt != 1) begin
            n_fail++; $display("FAIL str_overrun_err: got err=%b errs=%0d dones=%0d, required 1 1 1", e, err_cnt, done_cnt);
        end
    endtask

    task automatic test_unsupported();
        int lat; logic e;
        rdy_mode = 0;
        run_svc(32'd99, 32'h1234, lat, e);
        n_checks++;
        if (lat != 1 || e !== 1'b1 || outq.size() != 0 || addrq.size() != 0 || done_cnt != 1) begin
            n_fail++; $display("FAIL unsupported: got lat=%0d err=%b bytes=%0d reads=%0d dones=%0d, required 1 1 0 0 1",
                               lat, e, outq.size(), addrq.size(), done_cnt);
        end
    endtask

    task automatic test_random();
        int lat, ee, len, r; logic e;
        logic [31:0] code, arg, a;
        string eb, ea;
        for (int it = 0; it < 14; it++) begin
            r = $urandom_range(0, 3);
            code = (r == 0) ? 32'd4 : (r == 1) ? 32'd11 : (r == 2) ? 32'd34 : 32'(100 + $urandom_range(0, 1000));
            arg = $urandom;
            if (code == 32'd4) begin
                len = $urandom_range(0, 6);
                for (int i = 0; i < len; i++) begin
                    a = arg + 32'(i); mem[a[9:0]] = 8'($urandom_range(1, 255));
                end
                a = arg + 32'(len); mem[a[9:0]] = 8'h00;
            end
            rdy_mode = $urandom_range(0, 2);
            model(code, arg, eb, ea, ee);
            run_svc(code, arg, lat, e);
            n_checks++;
            if (bq2s() != eb || aq2s() != ea) begin
                n_fail++; $display("FAIL rand_%0d code=%0d arg=%h: got bytes '%s' addrs '%s', required '%s' / '%s'",
                                   it, code, arg, bq2s(), aq2s(), eb, ea);
            end
            n_checks++;
            if (e !== 1'(ee) || err_cnt != ee || done_cnt != 1 || lat < 1) begin
                n_fail++; $display("FAIL rand_status_%0d: got err=%b errs=%0d dones=%0d lat=%0d, required err=%0d dones=1",
                                   it, e, err_cnt, done_cnt, lat, ee);
            end
        end
    endtask

    task automatic test_reset_mid_hex();
        bit ok;
        rdy_mode = 2; clear_obs();
        send(32'd34, 32'h89ABCDEF, ok);
        repeat (3) @(posedge clk);
        rdy_mode = 3;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hex_stalled: got ov=%b, required 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_byte, req_ready, done} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL async_reset: got ov=%b ob=%h rdy=%b done=%b, required 0 00 1 0", out_valid, out_byte, req_ready, done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
    endtask

    task automatic test_exit();
        bit ok; int bad;
        rdy_mode = 0; clear_obs();
        send(32'd10, 32'h0, ok);
        @(negedge clk);
        n_checks++;
        if ({ok, done, halted, err} !== 4'b1110) begin
            n_fail++; $display("FAIL exit_pulse: got ok=%b done=%b halted=%b err=%b, required 1 1 1 0", ok, done, halted, err);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            req_valid = 1'b1; svc_code = 32'd11; svc_arg = 32'h55;
            @(negedge clk);
            if (req_ready !== 1'b0 || halted !== 1'b1 || out_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0 || done_cnt != 1 || outq.size() != 0) begin
            n_fail++; $display("FAIL halt_sticky: got bad=%0d dones=%0d bytes=%0d, required 0 1 0", bad, done_cnt, outq.size());
        end
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({halted, req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL halt_reset: got halted=%b rdy=%b, required 0 1", halted, req_ready);
        end
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_print_char();
        test_print_hex();
        test_print_string();
        test_empty_and_overrun();
        test_unsupported();
        test_random();
        test_reset_mid_hex();
        test_print_char();
        test_exit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/syscall_responder.md
SYSCALL_RESPONDER -- requirements
Module: syscall_responder

Interface
REQ-001 The block SHALL have parameter MAX_STR_LEN, default 256, giving the maximum number of bytes print_string emits before it aborts.
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the byte-address width of the memory read port.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have the following request ports:
- req_valid  in  1  syscall request from the CPU writeback stage.
- req_ready  out  1  responder is idle and accepts a request.
- svc_code  in  32  service number ($v0).
- svc_arg  in  32  argument ($a0).
REQ-005 The block SHALL have the following memory read ports:
- mem_rd_en  out  1  byte read strobe.
- mem_addr  out  ADDR_W  byte address.
- mem_rd_data  in  8  read data, valid exactly 1 cycle after the strobe.
REQ-006 The block SHALL have the following console ports:
- out_valid  out  1  console byte valid.
- out_ready  in  1  console sink ready.
- out_byte  out  8  ASCII byte.
REQ-007 The block SHALL have the following status ports:
- done  out  1  one-cycle pulse when a service completes.
- halted  out  1  sticky; exit service executed.
- err  out  1  one-cycle pulse, coincident with done, on an unsupported code or string overrun.

Function
REQ-008 A request SHALL be accepted on the rising edge where req_valid && req_ready; svc_code and svc_arg SHALL be latched on that edge, and later changes on those inputs SHALL be ignored.
REQ-009 req_ready SHALL be 1 only in IDLE; req_valid in any other state SHALL be ignored.
REQ-010 The FSM SHALL have states IDLE, STR_RD, STR_WAIT, EMIT, DONE and HALT.
REQ-011 Service 11 (print_char) SHALL emit svc_arg[7:0] once via EMIT, then go to DONE.
REQ-012 Service 34 (print_hex) SHALL emit 10 bytes: "0", "x", then 8 lowercase hex digits of svc_arg, most significant nibble first, using a 4-bit nibble counter.
REQ-013 Service 4 (print_string) SHALL proceed as follows:
- STR_RD asserts mem_rd_en for 1 cycle with mem_addr = svc_arg + offset.
- STR_WAIT samples mem_rd_data.
- A byte of 0x00 goes to DONE; any other byte goes to EMIT, then offset increments and the FSM returns to STR_RD.
REQ-014 print_string SHALL emit no bytes when the first byte read is 0x00.
REQ-015 print_string SHALL pulse err with done, without reading further, after MAX_STR_LEN bytes have been emitted with no terminator.
REQ-016 The offset SHALL wrap modulo 2^ADDR_W.
REQ-017 Service 10 (exit) SHALL pulse done, set halted, and enter HALT; HALT SHALL be left only by reset, and req_ready SHALL be 0 in HALT.
REQ-018 Any other svc_code SHALL go to DONE in the cycle after acceptance, with err=1 and no output.
REQ-019 In EMIT, out_valid=1 and out_byte SHALL be held stable until the edge where out_ready=1; the byte SHALL transfer on that edge, and stalls of any length SHALL be legal.
REQ-020 DONE SHALL last exactly 1 cycle with done=1 and SHALL return to IDLE, so req_ready=1 on the following cycle.
REQ-021 Latency for print_char with out_ready held at 1 SHALL be: accept at edge N, out_valid during cycle N+1, done during cycle N+2, req_ready during cycle N+3.

Reset
REQ-022 While rst_n=0, the block SHALL hold state=IDLE and the following output values:
- req_ready=1.
- mem_rd_en=0, mem_addr=0.
- out_valid=0, out_byte=0.
- done=0, err=0, halted=0.
- Internal offset and nibble counter = 0.
REQ-023 Reset asserted in the middle of an operation SHALL abort the operation immediately; bytes not yet transferred SHALL be lost.
REQ-024 After rst_n deasserts, req_ready SHALL be 1 on the first clock edge.

Structure
REQ-025 Shared package mips_sys_pkg SHALL hold the service-code constants (SVC_PRINT_STR=4, SVC_EXIT=10, SVC_PRINT_CHAR=11, SVC_PRINT_HEX=34) and the responder state enum.
REQ-026 Nibble-to-ASCII conversion SHALL be a single combinational sub-module, hex_nibble_ascii (0-9 map to 0x30-0x39, a-f map to 0x61-0x66).

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- code=11, arg=0x41, out_ready=1: exactly one byte 0x41 is emitted, and done pulses at cycle N+2.
- code=34, arg=0xDEADBEEF: the bytes "0xdeadbeef" (30 78 64 65 61 64 62 65 65 66) are emitted in order, with out_ready toggling every cycle.
- code=4, arg=0x100, memory holds "Hi\0": reads from 0x100, 0x101 and 0x102; output is 48 69; done follows.
- code=4 with mem[arg]=0: no bytes are emitted, done=1 and err=0; with MAX_STR_LEN=4 and no terminator, 4 bytes are emitted and err pulses.
- code=10, then req_valid held at 1: halted stays 1, req_ready stays 0, and no further done; rst_n low clears halted.
- code=99: done and err pulse together one cycle after acceptance; rst_n pulsed mid-way through a print_hex drops out_valid asynchronously.
